// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU datapath blocks.
//   DATA_W      : default width of MDR, bus and memory data
//   mdr_state_t : states of the MDR memory handshake sequencer
package cpu_bus_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_REQ = 2'd1,
        WR_REQ = 2'd2
    } mdr_state_t;

endpackage

// File: rtl/mdr_reg.sv
// Enabled data register with synchronous clear, holds the MDR contents.
// Ports:
//   clock : rising-edge clock
//   clear : synchronous active-high clear (q <= 0)
//   en    : load d on the next rising edge
//   d     : data to load
//   q     : register contents
module mdr_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] q_reg;

    always_ff @(posedge clock) begin
        if (clear) begin
            q_reg <= '0;
        end else if (en) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/mdr_mem_if.sv
// Memory Data Register with memory-side req/ack handshake sequencer.
// Captures a word from the bus or from memory, drives the MDR input of the
// bus mux and supplies write data to memory. The control unit issues
// start_rd / start_wr pulses and waits for the one-cycle done pulse.
//
// Optional feature: define MDR_TIMEOUT_EN to abort a request that waits
// TIMEOUT_CYCLES cycles without mem_ack (sets sticky timeout_err).
//
// Ports:
//   clock, clear        : clock and synchronous active-high reset
//   bus_in              : BusMuxOut value
//   mdr_in, read        : idle-time load strobe and source select (1 = mem_rdata)
//   start_rd, start_wr  : one-cycle transaction start pulses
//   mem_rdata, mem_ack  : memory read data and request completion
//   mem_req, mem_we     : registered request / write-enable to memory
//   mem_wdata, mdr_q    : MDR contents (write data and bus-mux input)
//   busy, done          : sequencer not idle / completion pulse
//   timeout_err         : sticky abort flag (0 when MDR_TIMEOUT_EN undefined)
module mdr_mem_if
    import cpu_bus_pkg::*;
#(
    parameter int DATA_W         = cpu_bus_pkg::DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              mdr_in,
    input  logic              read,
    input  logic              start_rd,
    input  logic              start_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mdr_q,
    output logic              busy,
    output logic              done,
    output logic              timeout_err
);

    mdr_state_t        state_reg, state_next;
    logic              done_reg, done_next;
    logic              load_en;
    logic [DATA_W-1:0] load_data;

`ifdef MDR_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             timeout_reg, timeout_next;
`endif

    mdr_reg #(.DATA_W(DATA_W)) u_mdr_reg (
        .clock (clock),
        .clear (clear),
        .en    (load_en),
        .d     (load_data),
        .q     (mdr_q)
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            state_reg <= IDLE;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
        end
    end

`ifdef MDR_TIMEOUT_EN
    always_ff @(posedge clock) begin
        if (clear) begin
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            cnt_reg     <= cnt_next;
            timeout_reg <= timeout_next;
        end
    end
`endif

    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        load_en    = 1'b0;
        load_data  = bus_in;
`ifdef MDR_TIMEOUT_EN
        cnt_next     = cnt_reg;
        timeout_next = timeout_reg;
`endif
        case (state_reg)
            IDLE: begin
                // A start pulse wins over mdr_in; read wins over write.
                if (start_rd || start_wr) begin
                    state_next = start_rd ? RD_REQ : WR_REQ;
`ifdef MDR_TIMEOUT_EN
                    cnt_next     = '0;
                    timeout_next = 1'b0;
`endif
                end else if (mdr_in) begin
                    load_en   = 1'b1;
                    load_data = read ? mem_rdata : bus_in;
                end
            end
            RD_REQ: begin
                if (mem_ack) begin
                    load_en    = 1'b1;
                    load_data  = mem_rdata;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            WR_REQ: begin
                if (mem_ack) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
`ifdef MDR_TIMEOUT_EN
        // Counter value is the number of wait cycles already spent; the
        // request is abandoned at the end of the TIMEOUT_CYCLES-th cycle.
        if (state_reg != IDLE && !mem_ack) begin
            if (cnt_reg == CNT_LAST) begin
                state_next   = IDLE;
                timeout_next = 1'b1;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
`endif
    end

    // Request outputs come straight from the state flop, so they rise the
    // cycle after the start pulse and fall the cycle after the ack.
    assign busy      = (state_reg != IDLE);
    assign mem_req   = busy;
    assign mem_we    = (state_reg == WR_REQ);
    assign mem_wdata = mdr_q;
    assign done      = done_reg;

`ifdef MDR_TIMEOUT_EN
    assign timeout_err = timeout_reg;
`else
    assign timeout_err = 1'b0;
`endif

endmodule
